latch_id_ex: RTL and testbench
==============================

// Module: latch_id_ex
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, with built-in load-use hazard detection.
//  - Captures decode results and feeds EX; its rs/rt outputs drive forwarding_unit.
//  - On a load-use hazard, an illegal flush, or a hold, it inserts a bubble or freezes.
//  - Counts inserted bubbles for the debug unit.
// PARAMETERS
//  LEN      32  datapath width (operands, immediate, pc+4)
//  NB_ADDR  5   register-file address width
//  NB_ALUOP 4   ALU control code width
//  NB_BCNT  16  bubble counter width
// PORTS
//  i_clk             in   1         core clock, rising edge
//  i_reset           in   1         synchronous, active-high
//  i_enable          in   1         debug step/run enable; 0 = freeze everything
//  i_flush           in   1         branch/jump taken in EX: squash ID instruction
//  i_pc_plus4        in   LEN       from IF/ID
//  i_read_data_1     in   LEN       register-file port 1
//  i_read_data_2     in   LEN       register-file port 2
//  i_sign_ext        in   LEN       sign-extended immediate
//  i_rs / i_rt / i_rd in  NB_ADDR   decoded register fields
//  i_reg_dst, i_alu_src, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write  in 1  control
//  i_alu_op          in   NB_ALUOP  ALU control
//  o_pc_plus4, o_read_data_1, o_read_data_2, o_sign_ext  out LEN      registered copies
//  o_rs_id_ex, o_rt_id_ex, o_rd_id_ex                     out NB_ADDR  registered fields
//  o_reg_dst..o_reg_write, o_alu_op                        out          registered control
//  o_valid           out  1         1 = slot holds a real instruction, 0 = bubble
//  o_stall           out  1         load-use hazard: hold PC and IF/ID this cycle
//  o_bubble_count    out  NB_BCNT   saturating count of bubbles inserted
// BEHAVIOUR
//  - Reset: all outputs 0, o_valid=0, o_bubble_count=0; o_stall=0 after the reset edge.
//  - Hazard (combinational): hz = o_mem_read & o_valid & (o_rt_id_ex!=0)
//    & (o_rt_id_ex==i_rs | o_rt_id_ex==i_rt).
//    o_stall = hz & ~i_flush. A flush overrides the stall because the ID instruction dies.
//  - Per rising edge, in priority order:
//    1 i_reset -> reset values.
//    2 ~i_enable -> all state holds, counter included.
//    3 i_flush | hz -> bubble: all control outputs incl. o_alu_op=0, o_valid=0.
//      Data and address fields still load from the inputs. Counter +1, saturating at all-ones.
//    4 else -> load all inputs; o_valid=1.
//  - Latency: one cycle from input to output; no combinational path from i_* to the registered outputs.
//  - A bubble has reg_write=0 and mem_write=0, so it never matches in forwarding_unit and never writes memory.
//  - Back-to-back hazards: a second lw using the first lw's rt stalls once per dependency.
//    After a bubble, o_valid=0, so hz=0 and the stall never exceeds one cycle.
//  - Reset asserted mid-stall clears the stall the next cycle; no pending state survives.
// STRUCTURE
//  - Package mips_pkg: NB_ALUOP, the ALU op codes, and the control bundle width/bit positions,
//    shared with the control unit and latch_ex_mem.
//  - Sub-module hazard_detection_unit: combinational, computes hz from
//    (o_mem_read, o_valid, o_rt_id_ex, i_rs, i_rt).
//  - Everything else is a single registered always block.
// TESTING
//  1 Reset with i_reset=1 for 2 cycles, inputs random -> every output 0, o_stall=0.
//  2 Load lw (mem_read=1, rt=5), then add with rs=5 ->
//    o_stall=1 one cycle, bubble inserted (o_valid=0, reg_write=0), count=1;
//    the add is captured the next cycle.
//  3 lw rt=0, then add rs=0 -> no stall; lw rt=7, then add rt=7 with i_flush=1 ->
//    o_stall=0, bubble inserted, count +1.
//  4 i_enable=0 for 3 cycles during a pending hazard ->
//    outputs and count frozen; stall resolves once enable=1.
//  5 Force 2^NB_BCNT+3 bubbles -> o_bubble_count saturates at all-ones.
//  6 Normal stream, 10 random R-type instructions -> each output equals the previous cycle's input;
//    o_valid=1 throughout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU op codes and the control bundle layout
// used by the control unit, latch_id_ex and latch_ex_mem.
package mips_pkg;

  localparam int NB_ALUOP = 4;

  // ALU control codes driven by the control unit
  typedef enum logic [NB_ALUOP-1:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hc
  } alu_op_e;

  // Control bundle carried down the pipeline, MSB first
  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic [NB_ALUOP-1:0] alu_op;
  } ctrl_t;

  localparam int NB_CTRL         = 6 + NB_ALUOP;
  localparam int CTRL_REG_DST    = NB_CTRL - 1;
  localparam int CTRL_ALU_SRC    = NB_CTRL - 2;
  localparam int CTRL_MEM_READ   = NB_CTRL - 3;
  localparam int CTRL_MEM_WRITE  = NB_CTRL - 4;
  localparam int CTRL_MEM_TO_REG = NB_CTRL - 5;
  localparam int CTRL_REG_WRITE  = NB_CTRL - 6;
  localparam int CTRL_ALU_OP_LSB = 0;

  // A bubble carries no side effects: no register write, no memory access
  function automatic ctrl_t bubble_ctrl();
    return '0;
  endfunction

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: the instruction in EX is a load whose
// destination (rt) is a source of the instruction currently in ID.
module hazard_detection_unit #(
  parameter int NB_ADDR = 5
) (
  input  logic               i_mem_read_id_ex,
  input  logic               i_valid_id_ex,
  input  logic [NB_ADDR-1:0] i_rt_id_ex,
  input  logic [NB_ADDR-1:0] i_rs_if_id,
  input  logic [NB_ADDR-1:0] i_rt_if_id,
  output logic               o_hazard
);

  // Register $0 is hardwired to zero, so a load into it never creates a dependency
  assign o_hazard = i_mem_read_id_ex & i_valid_id_ex & (i_rt_id_ex != '0)
                  & ((i_rt_id_ex == i_rs_if_id) | (i_rt_id_ex == i_rt_if_id));

endmodule

// File: rtl/latch_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter for the debug unit.
module latch_id_ex
  import mips_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BCNT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic [LEN-1:0]      i_pc_plus4,
  input  logic [LEN-1:0]      i_read_data_1,
  input  logic [LEN-1:0]      i_read_data_2,
  input  logic [LEN-1:0]      i_sign_ext,
  input  logic [NB_ADDR-1:0]  i_rs,
  input  logic [NB_ADDR-1:0]  i_rt,
  input  logic [NB_ADDR-1:0]  i_rd,
  input  logic                i_reg_dst,
  input  logic                i_alu_src,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_mem_to_reg,
  input  logic                i_reg_write,
  input  logic [NB_ALUOP-1:0] i_alu_op,
  output logic [LEN-1:0]      o_pc_plus4,
  output logic [LEN-1:0]      o_read_data_1,
  output logic [LEN-1:0]      o_read_data_2,
  output logic [LEN-1:0]      o_sign_ext,
  output logic [NB_ADDR-1:0]  o_rs_id_ex,
  output logic [NB_ADDR-1:0]  o_rt_id_ex,
  output logic [NB_ADDR-1:0]  o_rd_id_ex,
  output logic                o_reg_dst,
  output logic                o_alu_src,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic [NB_ALUOP-1:0] o_alu_op,
  output logic                o_valid,
  output logic                o_stall,
  output logic [NB_BCNT-1:0]  o_bubble_count
);

  logic [LEN-1:0]     pc_plus4_q;
  logic [LEN-1:0]     read_data_1_q;
  logic [LEN-1:0]     read_data_2_q;
  logic [LEN-1:0]     sign_ext_q;
  logic [NB_ADDR-1:0] rs_q;
  logic [NB_ADDR-1:0] rt_q;
  logic [NB_ADDR-1:0] rd_q;
  ctrl_t              ctrl_q;
  ctrl_t              ctrl_in;
  logic               valid_q;
  logic [NB_BCNT-1:0] bubble_count_q;
  logic               hazard;
  logic               bubble;

  assign ctrl_in = '{
    reg_dst:    i_reg_dst,
    alu_src:    i_alu_src,
    mem_read:   i_mem_read,
    mem_write:  i_mem_write,
    mem_to_reg: i_mem_to_reg,
    reg_write:  i_reg_write,
    alu_op:     i_alu_op
  };

  hazard_detection_unit #(
    .NB_ADDR(NB_ADDR)
  ) u_hazard_detection_unit (
    .i_mem_read_id_ex(ctrl_q.mem_read),
    .i_valid_id_ex   (valid_q),
    .i_rt_id_ex      (rt_q),
    .i_rs_if_id      (i_rs),
    .i_rt_if_id      (i_rt),
    .o_hazard        (hazard)
  );

  // A taken branch kills the ID instruction, so there is nothing left to stall for
  assign o_stall = hazard & ~i_flush;
  assign bubble  = hazard | i_flush;

  // Pipeline register: reset, freeze on ~enable, bubble on hazard/flush, else load
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (i_reset) begin
      pc_plus4_q     <= '0;
      read_data_1_q  <= '0;
      read_data_2_q  <= '0;
      sign_ext_q     <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      ctrl_q         <= '0;
      valid_q        <= 1'b0;
      bubble_count_q <= '0;
    end else if (i_enable) begin
      pc_plus4_q    <= i_pc_plus4;
      read_data_1_q <= i_read_data_1;
      read_data_2_q <= i_read_data_2;
      sign_ext_q    <= i_sign_ext;
      rs_q          <= i_rs;
      rt_q          <= i_rt;
      rd_q          <= i_rd;
      if (bubble) begin
        ctrl_q  <= bubble_ctrl();
        valid_q <= 1'b0;
        if (bubble_count_q != '1) begin
          bubble_count_q <= bubble_count_q + NB_BCNT'(1);
        end
      end else begin
        ctrl_q  <= ctrl_in;
        valid_q <= 1'b1;
      end
    end
  end

  assign o_pc_plus4     = pc_plus4_q;
  assign o_read_data_1  = read_data_1_q;
  assign o_read_data_2  = read_data_2_q;
  assign o_sign_ext     = sign_ext_q;
  assign o_rs_id_ex     = rs_q;
  assign o_rt_id_ex     = rt_q;
  assign o_rd_id_ex     = rd_q;
  assign o_reg_dst      = ctrl_q.reg_dst;
  assign o_alu_src      = ctrl_q.alu_src;
  assign o_mem_read     = ctrl_q.mem_read;
  assign o_mem_write    = ctrl_q.mem_write;
  assign o_mem_to_reg   = ctrl_q.mem_to_reg;
  assign o_reg_write    = ctrl_q.reg_write;
  assign o_alu_op       = ctrl_q.alu_op;
  assign o_valid        = valid_q;
  assign o_bubble_count = bubble_count_q;

endmodule

// File: tb/tb_latch_id_ex.sv
// Scoreboard bench for latch_id_ex: the driver pushes expected stall and
// register values from a behavioural model; two monitors pop and compare.
module tb_latch_id_ex;

  localparam int LEN     = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_BCNT = 16;
  localparam int NB_AOP  = 4;
  localparam logic [NB_BCNT-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [LEN-1:0]     pc, rd1, rd2, se;
    logic [NB_ADDR-1:0] rs, rt, rd;
    logic               reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic [NB_AOP-1:0]  alu_op;
  } in_t;

  typedef struct packed {
    in_t                f;
    logic               valid;
    logic [NB_BCNT-1:0] cnt;
  } st_t;

  logic                i_clk = 1'b0;
  logic                i_reset, i_enable, i_flush;
  in_t                 drv;
  logic [LEN-1:0]      o_pc_plus4, o_read_data_1, o_read_data_2, o_sign_ext;
  logic [NB_ADDR-1:0]  o_rs_id_ex, o_rt_id_ex, o_rd_id_ex;
  logic                o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic [NB_AOP-1:0]   o_alu_op;
  logic                o_valid, o_stall;
  logic [NB_BCNT-1:0]  o_bubble_count;

  int errors = 0;
  int checks = 0;

  st_t  model;
  bit   model_known = 0;
  logic stall_q[$];
  st_t  reg_q[$];

  always #5 i_clk = ~i_clk;

  latch_id_ex #(.LEN(LEN), .NB_ADDR(NB_ADDR), .NB_BCNT(NB_BCNT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_pc_plus4(drv.pc), .i_read_data_1(drv.rd1), .i_read_data_2(drv.rd2),
    .i_sign_ext(drv.se), .i_rs(drv.rs), .i_rt(drv.rt), .i_rd(drv.rd),
    .i_reg_dst(drv.reg_dst), .i_alu_src(drv.alu_src), .i_mem_read(drv.mem_read),
    .i_mem_write(drv.mem_write), .i_mem_to_reg(drv.mem_to_reg),
    .i_reg_write(drv.reg_write), .i_alu_op(drv.alu_op),
    .o_pc_plus4(o_pc_plus4), .o_read_data_1(o_read_data_1), .o_read_data_2(o_read_data_2),
    .o_sign_ext(o_sign_ext), .o_rs_id_ex(o_rs_id_ex), .o_rt_id_ex(o_rt_id_ex),
    .o_rd_id_ex(o_rd_id_ex), .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_alu_op(o_alu_op), .o_valid(o_valid),
    .o_stall(o_stall), .o_bubble_count(o_bubble_count)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load-use rule: previous slot is a real load into a nonzero register read by ID
  function automatic logic load_use(input st_t s, input in_t x);
    return s.f.mem_read && s.valid && (s.f.rt != 0) && (s.f.rt == x.rs || s.f.rt == x.rt);
  endfunction

  function automatic st_t model_next(input st_t s, input logic rst, input logic en,
                                     input logic fl, input in_t x);
    st_t n;
    if (rst) return '0;
    if (!en) return s;
    n.f = x;
    if (fl || load_use(s, x)) begin
      n.f.reg_dst = 0; n.f.alu_src = 0; n.f.mem_read = 0; n.f.mem_write = 0;
      n.f.mem_to_reg = 0; n.f.reg_write = 0; n.f.alu_op = '0;
      n.valid = 0;
      n.cnt   = (s.cnt == CNT_MAX) ? s.cnt : s.cnt + 1;
    end else begin
      n.valid = 1;
      n.cnt   = s.cnt;
    end
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.pc = $urandom; x.rd1 = $urandom; x.rd2 = $urandom; x.se = $urandom;
    x.rs = NB_ADDR'($urandom); x.rt = NB_ADDR'($urandom); x.rd = NB_ADDR'($urandom);
    {x.reg_dst, x.alu_src, x.mem_read, x.mem_write, x.mem_to_reg, x.reg_write} = 6'($urandom);
    x.alu_op = NB_AOP'($urandom);
    return x;
  endfunction

  function automatic in_t mk_lw(input logic [NB_ADDR-1:0] rt);
    in_t x = rand_in();
    x.rt = rt; x.mem_read = 1; x.mem_to_reg = 1; x.reg_write = 1;
    x.mem_write = 0; x.alu_src = 1; x.reg_dst = 0; x.alu_op = 4'h2;
    return x;
  endfunction

  function automatic in_t mk_rtype(input logic [NB_ADDR-1:0] rs, input logic [NB_ADDR-1:0] rt);
    in_t x = rand_in();
    x.rs = rs; x.rt = rt; x.mem_read = 0; x.mem_write = 0; x.mem_to_reg = 0;
    x.reg_write = 1; x.reg_dst = 1; x.alu_src = 0;
    return x;
  endfunction

  // One clock of stimulus: drive, then queue what the DUT must show
  task automatic step(input logic rst, input logic en, input logic fl, input in_t x);
    @(negedge i_clk);
    #1;
    i_reset = rst; i_enable = en; i_flush = fl; drv = x;
    if (model_known) stall_q.push_back(load_use(model, x) & ~fl);
    if (model_known || rst) begin
      model = model_next(model, rst, en, fl, x);
      model_known = 1;
      reg_q.push_back(model);
    end
  endtask

  task automatic after_edge();
    @(posedge i_clk);
    #3;
  endtask

  // Stall monitor: combinational output, sampled mid low phase
  initial forever begin
    @(negedge i_clk);
    #2;
    if (stall_q.size() > 0) check("stall", o_stall, stall_q.pop_front());
  end

  // Register monitor: sampled just after each rising edge
  initial forever begin
    st_t act;
    @(posedge i_clk);
    #1;
    if (reg_q.size() > 0) begin
      act.f = '{pc: o_pc_plus4, rd1: o_read_data_1, rd2: o_read_data_2, se: o_sign_ext,
                rs: o_rs_id_ex, rt: o_rt_id_ex, rd: o_rd_id_ex, reg_dst: o_reg_dst,
                alu_src: o_alu_src, mem_read: o_mem_read, mem_write: o_mem_write,
                mem_to_reg: o_mem_to_reg, reg_write: o_reg_write, alu_op: o_alu_op};
      act.valid = o_valid;
      act.cnt   = o_bubble_count;
      check("regs", act, reg_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1; i_enable = 0; i_flush = 0; drv = '0;

    // Reset for two cycles with random inputs
    step(1, $urandom, $urandom, rand_in());
    step(1, $urandom, $urandom, rand_in());

    // Load-use: lw rt=5 then add rs=5 -> one bubble, then the add is taken
    step(0, 1, 0, mk_lw(5));
    step(0, 1, 0, mk_rtype(5, 9));
    step(0, 1, 0, mk_rtype(5, 9));
    after_edge();
    check("count_after_load_use", o_bubble_count, 1);
    check("valid_after_load_use", o_valid, 1);

    // rt=0 never stalls; flush overrides a real hazard but still bubbles
    step(0, 1, 0, mk_lw(0));
    step(0, 1, 0, mk_rtype(0, 0));
    step(0, 1, 0, mk_lw(7));
    step(0, 1, 1, mk_rtype(3, 7));
    after_edge();
    check("count_after_flush", o_bubble_count, 2);
    check("valid_after_flush", o_valid, 0);

    // Freeze for three cycles with a pending hazard, then resolve
    step(0, 1, 0, mk_lw(9));
    for (int i = 0; i < 3; i++) step(0, 0, 0, mk_rtype(9, 1));
    step(0, 1, 0, mk_rtype(9, 1));
    step(0, 1, 0, mk_rtype(9, 1));
    after_edge();
    check("count_after_freeze", o_bubble_count, 3);

    // Drive enough flushes to saturate the counter
    for (int i = 0; i < (1 << NB_BCNT) + 3; i++) step(0, 1, 1, rand_in());
    after_edge();
    check("count_saturated", o_bubble_count, CNT_MAX);

    // Reset asserted while a stall is pending
    step(0, 1, 0, mk_lw(4));
    step(1, 1, 0, mk_rtype(4, 4));
    step(0, 1, 0, mk_rtype(4, 4));

    // Ten back-to-back R-type instructions
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, mk_rtype(NB_ADDR'($urandom), NB_ADDR'($urandom)));
    after_edge();
    check("valid_rtype_stream", o_valid, 1);

    // Mixed random traffic with narrow register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      in_t x = rand_in();
      x.rs = NB_ADDR'($urandom_range(0, 3));
      x.rt = NB_ADDR'($urandom_range(0, 3));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, x);
    end

    // Drain outstanding expectations
    for (int i = 0; i < 5 && (stall_q.size() > 0 || reg_q.size() > 0); i++) @(negedge i_clk);
    #4;
    checks++;
    if (stall_q.size() != 0 || reg_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d stall and %0d reg expectations left, expected 0",
               stall_q.size(), reg_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
